// File: rtl/gate_test_sequencer_if.sv
// rtl/gate_test_sequencer_if.sv - start/status and gate-block signals of the gate test sequencer
interface gate_test_sequencer_if;
    logic       start;
    logic       a_out;
    logic       b_out;
    logic [6:0] gate_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    modport master (
        output start,
        output gate_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  fail_vec
    );

    modport slave (
        input  start,
        input  gate_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output fail_vec
    );
endinterface

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - exhaustive 2-input gate block tester; GATE_SEQ_LOOP_EN lets DONE re-arm on start
module gate_test_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    gate_test_sequencer_if.slave   bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [2:0] AFTER_DRIVE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    logic [2:0] state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic       a_q;
    logic       b_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_q;
    logic [3:0] fail_q;
    logic [6:0] expected;

    // Reference response derived from the operands actually on the wires
    always_comb begin
        expected = {~(a_q ^ b_q), a_q ^ b_q, ~a_q, ~(a_q | b_q),
                    a_q | b_q, ~(a_q & b_q), a_q & b_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 3'd0;
            fail_q     <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx    <= 2'd0;
                        err_q  <= 3'd0;
                        fail_q <= 4'd0;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    a_q        <= idx[1];
                    b_q        <= idx[0];
                    settle_cnt <= SETTLE_INIT;
                    state      <= AFTER_DRIVE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (bus.gate_in != expected) begin
                        err_q       <= err_q + 3'd1;
                        fail_q[idx] <= 1'b1;
                    end
                    if (idx == 2'd3) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    pass_q <= (err_q == 3'd0);
`ifdef GATE_SEQ_LOOP_EN
                    if (bus.start) begin
                        idx    <= 2'd0;
                        err_q  <= 3'd0;
                        fail_q <= 4'd0;
                        state  <= DRIVE;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out    = a_q;
    assign bus.b_out    = b_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - scoreboard bench: lane 0 SETTLE_CYCLES=1, lane 1 SETTLE_CYCLES=0
module tb_gate_test_sequencer;

`ifdef GATE_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct {
        int         lane;
        int         start_cyc;
        int         done_cyc;
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] m0 [2];
    logic [6:0] m1 [2];

    exp_t sb[$];
    int   cyc;
    int   next_ok [2];
    int   loop_edge [2];
    bit   rst_seen;
    int   checks;
    int   failures;

    logic       dn_w [2];
    logic       bs_w [2];
    logic       ao_w [2];
    logic       bo_w [2];
    logic       ps_w [2];
    logic [2:0] ec_w [2];
    logic [3:0] fv_w [2];

    gate_test_sequencer_if bus0 ();
    gate_test_sequencer_if bus1 ();

    gate_test_sequencer #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gate_test_sequencer #(.SETTLE_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [6:0] ref_gates(input int a, input int b);
        logic [6:0] g;
        g[0] = (a == 1) && (b == 1);
        g[1] = !((a == 1) && (b == 1));
        g[2] = (a == 1) || (b == 1);
        g[3] = !((a == 1) || (b == 1));
        g[4] = (a == 0);
        g[5] = (a != b);
        g[6] = (a == b);
        return g;
    endfunction

    function automatic int settle_of(input int l);
        return (l == 0) ? 1 : 0;
    endfunction

    assign bus0.start   = start;
    assign bus1.start   = start;
    assign bus0.gate_in = (ref_gates(int'(bus0.a_out), int'(bus0.b_out)) & ~m0[0]) | m1[0];
    assign bus1.gate_in = (ref_gates(int'(bus1.a_out), int'(bus1.b_out)) & ~m0[1]) | m1[1];

    assign dn_w[0] = bus0.done;     assign dn_w[1] = bus1.done;
    assign bs_w[0] = bus0.busy;     assign bs_w[1] = bus1.busy;
    assign ao_w[0] = bus0.a_out;    assign ao_w[1] = bus1.a_out;
    assign bo_w[0] = bus0.b_out;    assign bo_w[1] = bus1.b_out;
    assign ps_w[0] = bus0.pass;     assign ps_w[1] = bus1.pass;
    assign ec_w[0] = bus0.err_cnt;  assign ec_w[1] = bus1.err_cnt;
    assign fv_w[0] = bus0.fail_vec; assign fv_w[1] = bus1.fail_vec;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Predicted outcome of a whole run, from the fault masks alone
    function automatic exp_t predict(input int l, input int c);
        exp_t e;
        logic [6:0] good;
        logic [6:0] seen;
        e.lane      = l;
        e.start_cyc = c;
        e.done_cyc  = c + 4 * (settle_of(l) + 2) + 1;
        e.err       = 3'd0;
        e.fv        = 4'd0;
        for (int n = 0; n < 4; n++) begin
            good = ref_gates(n / 2, n % 2);
            seen = (good & ~m0[l]) | m1[l];
            if (seen != good) begin
                e.err   = e.err + 3'd1;
                e.fv[n] = 1'b1;
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    always @(posedge clk) begin
        cyc      = cyc + 1;
        rst_seen = rst;
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                next_ok[l]   = cyc + 1;
                loop_edge[l] = -1;
            end else if (start && (cyc >= next_ok[l] || (LOOP && cyc == loop_edge[l]))) begin
                if (cyc < next_ok[l]) begin
                    foreach (sb[i]) begin
                        if (sb[i].lane == l && sb[i].done_cyc == cyc) begin
                            sb[i].err = 3'd0;
                            sb[i].fv  = 4'd0;
                        end
                    end
                end
                sb.push_back(predict(l, cyc));
                next_ok[l]   = sb[$].done_cyc + 1;
                loop_edge[l] = sb[$].done_cyc;
            end
        end
        if (rst) sb.delete();
    end

    task automatic chk(input string nm, input int l, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s lane=%0d cyc=%0d actual=%0d expected=%0d", nm, l, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int   k;
        logic bexp;
        int   v;
        for (int l = 0; l < 2; l++) begin
            if (rst_seen) begin
                chk("reset_outputs", l,
                    int'({bs_w[l], dn_w[l], ps_w[l], ao_w[l], bo_w[l], ec_w[l], fv_w[l]}), 0);
            end else begin
                k    = -1;
                bexp = 1'b0;
                foreach (sb[i]) begin
                    if (sb[i].lane == l) begin
                        if (k < 0) k = i;
                        if (sb[i].done_cyc > cyc) bexp = 1'b1;
                        if (sb[i].start_cyc < cyc && cyc < sb[i].done_cyc) begin
                            v = (cyc - sb[i].start_cyc - 1) / (settle_of(l) + 2);
                            chk("vector_ab", l, int'({ao_w[l], bo_w[l]}), v);
                        end
                    end
                end
                chk("busy", l, int'(bs_w[l]), int'(bexp));
                if (dn_w[l]) begin
                    if (k >= 0 && sb[k].done_cyc == cyc) begin
                        chk("pass", l, int'(ps_w[l]), int'(sb[k].pass));
                        chk("err_cnt", l, int'(ec_w[l]), int'(sb[k].err));
                        chk("fail_vec", l, int'(fv_w[l]), int'(sb[k].fv));
                        sb.delete(k);
                    end else begin
                        chk("unexpected_done", l, 1, 0);
                    end
                end
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].lane == l && sb[i].done_cyc < cyc) begin
                        chk("missing_done", l, 0, 1);
                        sb.delete(i);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
        tick(2);
    endtask

    initial begin
        int r;
        cyc       = 0;
        checks    = 0;
        failures  = 0;
        rst_seen  = 1'b0;
        next_ok   = '{0, 0};
        loop_edge = '{-1, -1};
        rst       = 1'b1;
        start     = 1'b0;
        m0        = '{7'h00, 7'h00};
        m1        = '{7'h00, 7'h00};
        tick(3);
        rst = 1'b0;
        tick(1);

        pulse();
        drain();

        m0 = '{7'h20, 7'h20};
        pulse();
        drain();

        m0 = '{7'h00, 7'h00};
        pulse();
        tick(3);
        pulse();
        drain();

        pulse();
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        pulse();
        drain();

        start = 1'b1;
        tick(40);
        start = 1'b0;
        drain();

        for (int it = 0; it < 30; it++) begin
            for (int l = 0; l < 2; l++) begin
                m0[l] = ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom);
                m1[l] = ($urandom_range(0, 2) == 0) ? 7'h00 : (7'($urandom) & 7'($urandom));
            end
            pulse();
            r = $urandom_range(0, 9);
            if (r < 3) begin
                tick($urandom_range(1, 12));
                pulse();
            end else if (r == 3) begin
                tick($urandom_range(0, 12));
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving the number of wait cycles between driving a vector and sampling the results (legal range 0..15).
REQ-002 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to run the test sequence.
REQ-005 SHALL have port a_out  output  1  operand a driven into the gate block.
REQ-006 SHALL have port b_out  output  1  operand b driven into the gate block.
REQ-007 SHALL have port gate_in  input  7  gate block results: [0]=AND, [1]=NAND, [2]=OR, [3]=NOR, [4]=NOT a, [5]=XOR, [6]=XNOR.
REQ-008 SHALL have port busy  output  1  high while the sequence runs (any state except IDLE).
REQ-009 SHALL have port done  output  1  one-cycle pulse at sequence end.
REQ-010 SHALL have port pass  output  1  result of the last completed run: 1 = all vectors matched.
REQ-011 SHALL have port err_cnt  output  3  number of failing vectors in the current or last run (0..4).
REQ-012 SHALL have port fail_vec  output  4  bit n set = vector n ({a,b}=n) mismatched.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE and DONE; a 2-bit vector index idx SHALL walk 0,1,2,3.
REQ-014 IDLE: start=1 SHALL clear idx, err_cnt and fail_vec and go to DRIVE; otherwise the FSM SHALL stay in IDLE.
REQ-015 DRIVE: the FSM SHALL register a_out=idx[1] and b_out=idx[0], load the settle counter with SETTLE_CYCLES, and go to SETTLE, or go directly to SAMPLE if SETTLE_CYCLES=0.
REQ-016 SETTLE: the FSM SHALL decrement the counter and go to SAMPLE on the cycle the counter reaches 0.
REQ-017 SAMPLE: the FSM SHALL compare gate_in with the expected value computed from the registered a_out/b_out; on any bit mismatch it SHALL increment err_cnt and set fail_vec[idx].
REQ-018 SAMPLE: if idx=3 the FSM SHALL go to DONE; otherwise it SHALL increment idx and go to DRIVE.
REQ-019 DONE: the FSM SHALL assert done for exactly one cycle, load pass=(err_cnt==0) (counting the final vector's update), and go to IDLE.
REQ-020 done SHALL assert exactly 4*(SETTLE_CYCLES+2)+1 cycles after the edge at which start was sampled in IDLE.
REQ-021 start SHALL be ignored outside IDLE (and outside DONE when the loop option is enabled).
REQ-022 pass, err_cnt and fail_vec SHALL hold their values after DONE until the next accepted start.
REQ-023 err_cnt SHALL NOT wrap; its maximum is 4 by construction.

Reset
REQ-024 When rst=1 at a clock edge: state=IDLE, idx=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
REQ-025 rst SHALL take priority over start and over every state.
REQ-026 A reset mid-run SHALL abort the run with no done pulse.

Configuration
REQ-027 With macro GATE_SEQ_LOOP_EN defined, DONE with start=1 SHALL go directly to DRIVE, clearing idx, err_cnt and fail_vec while still pulsing done and updating pass.
REQ-028 With GATE_SEQ_LOOP_EN undefined, DONE SHALL always go to IDLE.

Verification
REQ-029 Correct gate model, SETTLE_CYCLES=1, one-cycle start -> a_out/b_out sequence 00,01,10,11; done at cycle 13; pass=1, err_cnt=0, fail_vec=0000.
REQ-030 gate_in[5] (XOR) stuck at 0 -> err_cnt=2, fail_vec=0110, pass=0.
REQ-031 SETTLE_CYCLES=0 -> done at cycle 9; all other results as in REQ-029.
REQ-032 Second start pulse at cycle 5 of a run -> ignored; exactly one done, at cycle 13.
REQ-033 rst at cycle 6 -> next cycle all outputs 0 and busy=0, no done; a new start then completes normally at +13.
REQ-034 GATE_SEQ_LOOP_EN defined, start held high, SETTLE_CYCLES=1 -> done pulses every 13 cycles; dropping start returns the FSM to IDLE after the current run.
